ahb_lite_initiator: RTL and testbench

Synthesizable AHB initiator (bus master) that turns a simple valid/ready command stream into pipelined single-beat AHB transfers. It is the counterpart of the AHB slave/RAM side of the bench: it drives address/control/write data and samples hready/hresp/hrdata/hgrant. It also serves as the RTL stimulus engine that feeds the AHB-RAM and GPIO bridge in system-level runs.

---
 rtl/ahb_lite_initiator.sv | 213 +++++++++++++++++++++
 tb/tb_ahb_lite_initiator.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_initiator.sv
// AHB-Lite initiator: turns a valid/ready command stream into pipelined single-beat AHB transfers.
// Define AHB_INITIATOR_ARB_EN to enable the hbusreq/hgrant arbitration FSM.
module ahb_lite_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [3:0]            hprot,
  output logic [1:0]            htrans,
  output logic [DATA_WIDTH-1:0] hwdata,
  output logic                  hbusreq,
  output logic                  hlock,
  input  logic                  hready,
  input  logic [1:0]            hresp,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hgrant
);

  localparam logic [1:0] HRESP_OKAY   = 2'b00;
  localparam logic [1:0] HRESP_ERROR  = 2'b01;
  localparam logic [1:0] HTRANS_IDLE  = 2'b00;
  localparam logic [1:0] HTRANS_NSEQ  = 2'b10;

  // A: address phase, D: data phase, R: transfer parked behind a retried beat
  logic                  a_valid_reg, d_valid_reg, r_valid_reg;
  logic                  a_write_reg, d_write_reg, r_write_reg;
  logic [ADDR_WIDTH-1:0] a_addr_reg,  d_addr_reg,  r_addr_reg;
  logic [2:0]            a_size_reg,  d_size_reg,  r_size_reg;
  logic [DATA_WIDTH-1:0] a_wdata_reg, d_wdata_reg, r_wdata_reg;
  logic                  hold_reg;
  logic                  rsp_valid_reg, rsp_err_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg;

  logic owned;
  logic granted;
  logic issue;
  logic a_adv;
  logic d_done;
  logic d_fail;
  logic d_retry;
  logic accept;

`ifdef AHB_INITIATOR_ARB_EN
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_REQ  = 2'b01,
    ARB_OWN  = 2'b10
  } arb_state_t;

  arb_state_t state_reg, state_next;
  logic       work;
  logic       busreq_next;

  assign work = cmd_valid | a_valid_reg | d_valid_reg | r_valid_reg;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) state_reg <= ARB_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    busreq_next = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (work) state_next = ARB_REQ;
      end
      ARB_REQ: begin
        busreq_next = 1'b1;
        if (hgrant && hready) state_next = ARB_OWN;
      end
      ARB_OWN: begin
        busreq_next = work;
        if (!work)                 state_next = ARB_IDLE;
        else if (hready && !hgrant) state_next = ARB_REQ;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  assign hbusreq = busreq_next;
  assign owned   = (state_reg == ARB_OWN);
  assign granted = owned && hgrant;
`else
  // Bus is permanently requested; this flag also keeps cmd_ready low during reset
  logic live_reg;
  logic unused_hgrant;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) live_reg <= 1'b0;
    else        live_reg <= 1'b1;
  end

  assign unused_hgrant = hgrant;
  assign hbusreq       = live_reg;
  assign owned         = live_reg;
  assign granted       = live_reg;
`endif

  assign d_done  = d_valid_reg && hready;
  assign d_fail  = d_done && (hresp != HRESP_OKAY);
  assign d_retry = d_fail && hresp[1];
  assign issue   = a_valid_reg && !hold_reg && owned;
  assign a_adv   = issue && hready && !d_fail;

  assign cmd_ready = granted && !hold_reg && !r_valid_reg && (!a_valid_reg || hready);
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      a_valid_reg   <= 1'b0;
      a_write_reg   <= 1'b0;
      a_addr_reg    <= '0;
      a_size_reg    <= '0;
      a_wdata_reg   <= '0;
      d_valid_reg   <= 1'b0;
      d_write_reg   <= 1'b0;
      d_addr_reg    <= '0;
      d_size_reg    <= '0;
      d_wdata_reg   <= '0;
      r_valid_reg   <= 1'b0;
      r_write_reg   <= 1'b0;
      r_addr_reg    <= '0;
      r_size_reg    <= '0;
      r_wdata_reg   <= '0;
      hold_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      if (d_done) d_valid_reg <= 1'b0;

      if (d_retry) begin
        // Retried beat goes back to the address phase; any queued A waits in R
        a_valid_reg <= 1'b1;
        a_write_reg <= d_write_reg;
        a_addr_reg  <= d_addr_reg;
        a_size_reg  <= d_size_reg;
        a_wdata_reg <= d_wdata_reg;
        r_valid_reg <= a_valid_reg;
        r_write_reg <= a_write_reg;
        r_addr_reg  <= a_addr_reg;
        r_size_reg  <= a_size_reg;
        r_wdata_reg <= a_wdata_reg;
      end else if (a_adv) begin
        d_valid_reg <= 1'b1;
        d_write_reg <= a_write_reg;
        d_addr_reg  <= a_addr_reg;
        d_size_reg  <= a_size_reg;
        d_wdata_reg <= a_wdata_reg;
        if (r_valid_reg) begin
          r_valid_reg <= 1'b0;
          a_write_reg <= r_write_reg;
          a_addr_reg  <= r_addr_reg;
          a_size_reg  <= r_size_reg;
          a_wdata_reg <= r_wdata_reg;
        end else if (accept) begin
          a_write_reg <= cmd_write;
          a_addr_reg  <= cmd_addr;
          a_size_reg  <= cmd_size;
          a_wdata_reg <= cmd_wdata;
        end else begin
          a_valid_reg <= 1'b0;
        end
      end else if (accept) begin
        a_valid_reg <= 1'b1;
        a_write_reg <= cmd_write;
        a_addr_reg  <= cmd_addr;
        a_size_reg  <= cmd_size;
        a_wdata_reg <= cmd_wdata;
      end

      // First cycle of a two-cycle response cancels the pending address phase
      if (d_fail)
        hold_reg <= 1'b0;
      else if (d_valid_reg && !hready && (hresp != HRESP_OKAY))
        hold_reg <= 1'b1;

      rsp_valid_reg <= d_done && !d_retry;
      if (d_done && !d_retry) begin
        rsp_err_reg   <= (hresp == HRESP_ERROR);
        rsp_rdata_reg <= d_write_reg ? '0 : hrdata;
      end
    end
  end

  assign htrans    = issue ? HTRANS_NSEQ : HTRANS_IDLE;
  assign haddr     = a_addr_reg;
  assign hwrite    = a_write_reg;
  assign hsize     = a_size_reg;
  assign hburst    = 3'b000;
  assign hprot     = 4'b0011;
  assign hlock     = 1'b0;
  assign hwdata    = d_wdata_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_ahb_lite_initiator.sv
// Self-checking bench for ahb_lite_initiator: vector table, pipelined/error/retry/reset sequences
// and a response scoreboard. Honours AHB_INITIATOR_ARB_EN for the grant test.
module tb_ahb_lite_initiator;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          hclk, hreset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    cmd_size;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] haddr;
  logic          hwrite, hbusreq, hlock, hready, hgrant;
  logic [2:0]    hsize, hburst;
  logic [3:0]    hprot;
  logic [1:0]    htrans, hresp;
  logic [DW-1:0] hwdata, hrdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            at_cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [DW-1:0] wdata;
    int            waits;
    logic [DW-1:0] bus_rdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;
  vec_t vecs[4];

  ahb_lite_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .htrans(htrans), .hwdata(hwdata), .hbusreq(hbusreq), .hlock(hlock),
    .hready(hready), .hresp(hresp), .hrdata(hrdata), .hgrant(hgrant)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  always @(posedge hclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor / scoreboard
  always @(negedge hclk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 rdata=%h expected no response", rsp_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("rsp cyc=%0d rdata=%h err=%b", cyc, rsp_rdata, rsp_err);
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        if (e.at_cyc >= 0) check("rsp_cycle", 64'(cyc), 64'(e.at_cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(posedge hclk); #1;
      n++;
    end
    check("cmd_ready_wait", 64'(cmd_ready), 64'(1'b1));
  endtask

  task automatic set_cmd(input logic wr, input logic [AW-1:0] a, input logic [2:0] sz,
                         input logic [DW-1:0] wd);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_size  = sz;
    cmd_wdata = wd;
  endtask

  task automatic tick();
    @(posedge hclk); #1;
  endtask

  initial begin
    int c1;
    hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_wdata = '0; hready = 1'b1; hresp = 2'b00; hrdata = '0; hgrant = 1'b1;

    vecs[0] = '{wr: 1'b1, addr: 32'h100, size: 3'd2, wdata: 32'hDEADBEEF, waits: 0,
                bus_rdata: 32'h0, exp_rdata: 32'h0};
    vecs[1] = '{wr: 1'b0, addr: 32'h104, size: 3'd2, wdata: 32'h0, waits: 3,
                bus_rdata: 32'h12345678, exp_rdata: 32'h12345678};
    vecs[2] = '{wr: 1'b1, addr: 32'h33, size: 3'd0, wdata: 32'h0000005A, waits: 1,
                bus_rdata: 32'h0, exp_rdata: 32'h0};
    vecs[3] = '{wr: 1'b0, addr: 32'h42, size: 3'd1, wdata: 32'h0, waits: 2,
                bus_rdata: 32'h0000BEEF, exp_rdata: 32'h0000BEEF};

    // Reset values
    repeat (2) @(posedge hclk);
    #1;
    check("rst_htrans", 64'(htrans), 64'(2'b00));
    check("rst_haddr", 64'(haddr), 64'(0));
    check("rst_hwdata", 64'(hwdata), 64'(0));
    check("rst_hprot", 64'(hprot), 64'(4'b0011));
    check("rst_hburst", 64'(hburst), 64'(0));
    check("rst_hlock", 64'(hlock), 64'(0));
    check("rst_hbusreq", 64'(hbusreq), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    #3 hreset = 1'b0;
    tick();

    // Single transfers from the vector table
    for (int i = 0; i < 4; i++) begin
      set_cmd(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata);
      wait_ready();
      tick();
      cmd_valid = 1'b0;
      sb.push_back('{rdata: vecs[i].exp_rdata, err: 1'b0, at_cyc: cyc + 2 + vecs[i].waits});
      $display("cmd %0d wr=%b addr=%h wdata=%h waits=%0d", i, vecs[i].wr, vecs[i].addr,
               vecs[i].wdata, vecs[i].waits);
      check("vec_htrans", 64'(htrans), 64'(2'b10));
      check("vec_haddr", 64'(haddr), 64'(vecs[i].addr));
      check("vec_hwrite", 64'(hwrite), 64'(vecs[i].wr));
      check("vec_hsize", 64'(hsize), 64'(vecs[i].size));
      check("vec_hburst", 64'(hburst), 64'(3'b000));
      check("vec_hprot", 64'(hprot), 64'(4'b0011));
      tick();
      check("vec_htrans_idle", 64'(htrans), 64'(2'b00));
      if (vecs[i].wr) check("vec_hwdata", 64'(hwdata), 64'(vecs[i].wdata));
      for (int w = 0; w < vecs[i].waits; w++) begin
        hready = 1'b0;
        hrdata = 32'hFFFF_FFFF;
        tick();
        check("wait_haddr", 64'(haddr), 64'(vecs[i].addr));
        if (vecs[i].wr) check("wait_hwdata", 64'(hwdata), 64'(vecs[i].wdata));
      end
      hready = 1'b1;
      hrdata = vecs[i].bus_rdata;
      tick();
      hrdata = '0;
      tick();
    end

    // Four back-to-back writes
    set_cmd(1'b1, 32'h0, 3'd2, 32'h1000_0000);
    wait_ready();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) check("b2b_ready", 64'(cmd_ready), 64'(1'b1));
      tick();
      sb.push_back('{rdata: 32'h0, err: 1'b0, at_cyc: cyc + 2});
      $display("cmd b2b %0d addr=%h", k, 32'(k * 4));
      check("b2b_htrans", 64'(htrans), 64'(2'b10));
      check("b2b_haddr", 64'(haddr), 64'(k * 4));
      if (k > 0) check("b2b_hwdata", 64'(hwdata), 64'(32'h1000_0000 + k - 1));
      if (k < 3) set_cmd(1'b1, 32'((k + 1) * 4), 3'd2, 32'h1000_0000 + k + 1);
      else cmd_valid = 1'b0;
    end
    tick();
    check("b2b_hwdata_last", 64'(hwdata), 64'(32'h1000_0003));
    check("b2b_idle", 64'(htrans), 64'(2'b00));
    repeat (3) tick();

    // ERROR on the first of two pipelined reads
    set_cmd(1'b0, 32'h200, 3'd2, 32'h0);
    wait_ready();
    tick();
    c1 = cyc;
    sb.push_back('{rdata: 32'h0, err: 1'b1, at_cyc: c1 + 3});
    $display("cmd err-read addr=00000200");
    set_cmd(1'b0, 32'h204, 3'd2, 32'h0);
    check("err_ready2", 64'(cmd_ready), 64'(1'b1));
    tick();
    cmd_valid = 1'b0;
    sb.push_back('{rdata: 32'hCAFE0204, err: 1'b0, at_cyc: c1 + 5});
    $display("cmd err-read addr=00000204");
    hready = 1'b0; hresp = 2'b01;
    tick();
    check("err_htrans_idle", 64'(htrans), 64'(2'b00));
    check("err_ready_low", 64'(cmd_ready), 64'(1'b0));
    hready = 1'b1;
    tick();
    hresp = 2'b00;
    check("err_reissue_htrans", 64'(htrans), 64'(2'b10));
    check("err_reissue_haddr", 64'(haddr), 64'(32'h204));
    tick();
    hrdata = 32'hCAFE0204;
    tick();
    hrdata = '0;
    repeat (2) tick();

    // RETRY on write 0x20 with read 0x24 queued behind it
    set_cmd(1'b1, 32'h20, 3'd2, 32'h2020);
    wait_ready();
    tick();
    c1 = cyc;
    sb.push_back('{rdata: 32'h0, err: 1'b0, at_cyc: c1 + 5});
    $display("cmd retry-write addr=00000020");
    set_cmd(1'b0, 32'h24, 3'd2, 32'h0);
    tick();
    cmd_valid = 1'b0;
    sb.push_back('{rdata: 32'h2424, err: 1'b0, at_cyc: c1 + 6});
    $display("cmd retry-read addr=00000024");
    hready = 1'b0; hresp = 2'b10;
    tick();
    check("rty_htrans_idle", 64'(htrans), 64'(2'b00));
    hready = 1'b1;
    tick();
    hresp = 2'b00;
    check("rty_htrans", 64'(htrans), 64'(2'b10));
    check("rty_haddr_w", 64'(haddr), 64'(32'h20));
    check("rty_hwrite_w", 64'(hwrite), 64'(1'b1));
    check("rty_ready_low", 64'(cmd_ready), 64'(1'b0));
    tick();
    check("rty_haddr_r", 64'(haddr), 64'(32'h24));
    check("rty_hwrite_r", 64'(hwrite), 64'(1'b0));
    check("rty_htrans_r", 64'(htrans), 64'(2'b10));
    check("rty_hwdata", 64'(hwdata), 64'(32'h2020));
    tick();
    hrdata = 32'h2424;
    tick();
    hrdata = '0;
    repeat (2) tick();

    // Reset during a read wait state: no response for the dropped read
    set_cmd(1'b0, 32'h300, 3'd2, 32'h77);
    wait_ready();
    tick();
    cmd_valid = 1'b0;
    $display("cmd reset-read addr=00000300");
    tick();
    hready = 1'b0;
    tick();
    #2 hreset = 1'b1;
    #1;
    check("mid_rst_htrans", 64'(htrans), 64'(2'b00));
    check("mid_rst_haddr", 64'(haddr), 64'(0));
    check("mid_rst_hwdata", 64'(hwdata), 64'(0));
    check("mid_rst_hbusreq", 64'(hbusreq), 64'(0));
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    hready = 1'b1;
    repeat (2) tick();
    check("mid_rst_no_rsp", 64'(rsp_valid), 64'(0));
    #2 hreset = 1'b0;
    repeat (2) tick();

`ifdef AHB_INITIATOR_ARB_EN
    // Grant withheld for 5 cycles: request stays up, nothing issued
    hgrant = 1'b0;
    set_cmd(1'b1, 32'h400, 3'd2, 32'h4444);
    tick();
    for (int g = 0; g < 5; g++) begin
      check("arb_hbusreq", 64'(hbusreq), 64'(1'b1));
      check("arb_no_nonseq", 64'(htrans), 64'(2'b00));
      check("arb_ready_low", 64'(cmd_ready), 64'(1'b0));
      tick();
    end
    hgrant = 1'b1;
    wait_ready();
    tick();
    cmd_valid = 1'b0;
    sb.push_back('{rdata: 32'h0, err: 1'b0, at_cyc: cyc + 2});
    $display("cmd arb-write addr=00000400");
    check("arb_htrans", 64'(htrans), 64'(2'b10));
    repeat (4) tick();
`endif

    repeat (3) tick();
    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
